// File: rtl/hf_pkg.sv
// Shared definitions for the HF reader receive datapath.
// Contents: mode encodings driven on mod_type, and the edge-filter output width helper.
package hf_pkg;

  // mod_type encodings shared with the rest of the HF image
  localparam logic [2:0] SNIFFER       = 3'b000;
  localparam logic [2:0] TAGSIM_LISTEN = 3'b001;
  localparam logic [2:0] TAGSIM_MOD    = 3'b010;
  localparam logic [2:0] READER_LISTEN = 3'b011;
  localparam logic [2:0] READER_MOD    = 3'b100;

  // Filter output width. Each term is at most 3*(2^adc_w-1), so the signed difference
  // needs adc_w+2 magnitude bits plus a sign bit.
  function automatic int unsigned filt_w(input int unsigned adc_w);
    return adc_w + 3;
  endfunction

endpackage

// File: rtl/hf_edge_filter.sv
// Gaussian-derivative edge filter on ADC samples.
// Ports:
//   clk_i    - clock; state updates on the falling edge
//   rst_i    - synchronous active-high reset, clears the delay line
//   adc_d_i  - unsigned ADC sample
//   f_o      - signed filter output (2*p4 + p3) - (2*adc + p1), combinational
// The delay line p1..p4 (p1 newest) shifts every tick; f_o uses the pre-shift values.
module hf_edge_filter
  import hf_pkg::*;
#(
  parameter int unsigned ADC_W = 8,
  localparam int unsigned FW   = filt_w(ADC_W)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADC_W-1:0]     adc_d_i,
  output logic signed [FW-1:0] f_o
);

  logic [ADC_W-1:0] p1_q, p2_q, p3_q, p4_q;
  logic [FW-1:0]    sum_old, sum_new;

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      p1_q <= '0;
      p2_q <= '0;
      p3_q <= '0;
      p4_q <= '0;
    end else begin
      p1_q <= adc_d_i;
      p2_q <= p1_q;
      p3_q <= p2_q;
      p4_q <= p3_q;
    end
  end

  always_comb begin
    sum_old = {2'b00, p4_q, 1'b0} + {3'b000, p3_q};
    sum_new = {2'b00, adc_d_i, 1'b0} + {3'b000, p1_q};
    // Modular subtraction reinterpreted as signed; the range always fits FW bits.
    f_o     = $signed(sum_old - sum_new);
  end

endmodule

// File: rtl/hf_reader_rx_engine.sv
// HF reader-side receive datapath: edge filter, subcarrier detector, frame assembler,
// SSP clock/frame/data generator and registered carrier enable.
// Ports:
//   osc_clk        - sole clock, all state on the falling edge
//   reset          - synchronous active-high reset
//   adc_d          - ADC sample
//   mod_type       - operating mode (READER_LISTEN / READER_MOD / idle)
//   edge_threshold - detector threshold, unsigned
//   resync         - single-tick pulse realigning bit/frame timing
//   ssp_dout       - ARM modulation request (1 = pause carrier)
//   ssp_clk, ssp_frame, ssp_din - SSP link toward the ARM
//   pwr_hi_en      - carrier enable
//   curbit         - current detector decision
//   rx_byte        - last assembled frame, MSB oldest; rx_valid pulses when it updates
// Optional: define HF_RX_GLITCH_FILTER_EN to require two agreeing windows before curbit moves.
module hf_reader_rx_engine
  import hf_pkg::*;
#(
  parameter int unsigned ADC_W       = 8,
  parameter int unsigned BIT_TICKS   = 16,
  parameter int unsigned FRAME_BITS  = 8,
  parameter int unsigned RESET_PHASE = 4
) (
  input  logic                  osc_clk,
  input  logic                  reset,
  input  logic [ADC_W-1:0]      adc_d,
  input  logic [2:0]            mod_type,
  input  logic [7:0]            edge_threshold,
  input  logic                  resync,
  input  logic                  ssp_dout,
  output logic                  ssp_clk,
  output logic                  ssp_frame,
  output logic                  ssp_din,
  output logic                  pwr_hi_en,
  output logic                  curbit,
  output logic [FRAME_BITS-1:0] rx_byte,
  output logic                  rx_valid
);

  localparam int unsigned FW         = filt_w(ADC_W);
  localparam int unsigned TotalTicks = BIT_TICKS * FRAME_BITS;
  localparam int unsigned CntW       = $clog2(TotalTicks);
  localparam int unsigned PhW        = $clog2(BIT_TICKS);

  logic signed [FW-1:0]  f, thr, neg_thr;
  logic signed [FW-1:0]  fall_max_q, fall_max_d, rise_max_q, rise_max_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [PhW-1:0]        phase;
  logic [FRAME_BITS-1:0] sr_q, sr_d, rx_byte_q, rx_byte_d;
  logic curbit_q, curbit_d, ssp_din_q, ssp_din_d, ssp_clk_q, ssp_clk_d;
  logic ssp_frame_q, ssp_frame_d, pwr_q, pwr_d, rx_valid_q, rx_valid_d;
  logic cnt_last, f_pos, decision, curbit_next;

  hf_edge_filter #(
    .ADC_W (ADC_W)
  ) u_edge_filter (
    .clk_i   (osc_clk),
    .rst_i   (reset),
    .adc_d_i (adc_d),
    .f_o     (f)
  );

  assign phase    = cnt_q[PhW-1:0];
  assign cnt_last = (cnt_q == CntW'(TotalTicks - 1));
  assign f_pos    = ~f[FW-1] & (|f);
  assign thr      = $signed({{(FW-8){1'b0}}, edge_threshold});
  assign neg_thr  = -thr;
  // Subcarrier present only if both a strong falling and a strong rising edge were seen
  assign decision = (fall_max_q > thr) && (rise_max_q < neg_thr);

`ifdef HF_RX_GLITCH_FILTER_EN
  logic dec_prev_q;

  always_ff @(negedge osc_clk) begin
    if (reset) begin
      dec_prev_q <= 1'b0;
    end else if (!resync && phase == PhW'(RESET_PHASE)) begin
      dec_prev_q <= decision;
    end
  end

  // Move only when this window and the previous one agree
  assign curbit_next = (decision == dec_prev_q) ? decision : curbit_q;
`else
  assign curbit_next = decision;
`endif

  always_comb begin
    cnt_d       = cnt_last ? '0 : cnt_q + 1'b1;
    fall_max_d  = fall_max_q;
    rise_max_d  = rise_max_q;
    sr_d        = sr_q;
    curbit_d    = curbit_q;
    ssp_din_d   = ssp_din_q;
    ssp_clk_d   = ssp_clk_q;
    ssp_frame_d = ssp_frame_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;

    case (mod_type)
      READER_LISTEN: pwr_d = 1'b1;
      READER_MOD:    pwr_d = ~ssp_dout;
      default:       pwr_d = 1'b0;
    endcase

    if (phase == PhW'(RESET_PHASE)) begin
      // Evaluate and restart the window; this tick's sample is dropped
      curbit_d   = curbit_next;
      fall_max_d = '0;
      rise_max_d = '0;
    end else if (f_pos && (f > fall_max_q)) begin
      fall_max_d = f;
    end else if (!f_pos && (f < rise_max_q)) begin
      rise_max_d = f;
    end

    if (phase == '0) begin
      sr_d      = {sr_q[FRAME_BITS-2:0], curbit_q};
      ssp_din_d = (mod_type == READER_LISTEN) && curbit_q;
      ssp_clk_d = 1'b1;
    end
    if (phase == PhW'(BIT_TICKS / 2)) ssp_clk_d = 1'b0;

    if (cnt_q == CntW'(BIT_TICKS / 2 - 1))             ssp_frame_d = 1'b1;
    if (cnt_q == CntW'(BIT_TICKS + BIT_TICKS / 2 - 1)) ssp_frame_d = 1'b0;

    if (cnt_last) begin
      rx_byte_d  = sr_q;
      rx_valid_d = 1'b1;
    end

    if (resync) begin
      // Truncated frame is dropped; decision/data outputs keep their last value
      cnt_d       = '0;
      fall_max_d  = '0;
      rise_max_d  = '0;
      sr_d        = '0;
      ssp_clk_d   = 1'b0;
      ssp_frame_d = 1'b0;
      rx_valid_d  = 1'b0;
      curbit_d    = curbit_q;
      ssp_din_d   = ssp_din_q;
      rx_byte_d   = rx_byte_q;
    end
  end

  always_ff @(negedge osc_clk) begin
    if (reset) begin
      cnt_q       <= '0;
      fall_max_q  <= '0;
      rise_max_q  <= '0;
      sr_q        <= '0;
      curbit_q    <= 1'b0;
      ssp_din_q   <= 1'b0;
      ssp_clk_q   <= 1'b0;
      ssp_frame_q <= 1'b0;
      pwr_q       <= 1'b0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      fall_max_q  <= fall_max_d;
      rise_max_q  <= rise_max_d;
      sr_q        <= sr_d;
      curbit_q    <= curbit_d;
      ssp_din_q   <= ssp_din_d;
      ssp_clk_q   <= ssp_clk_d;
      ssp_frame_q <= ssp_frame_d;
      pwr_q       <= pwr_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign ssp_clk   = ssp_clk_q;
  assign ssp_frame = ssp_frame_q;
  assign ssp_din   = ssp_din_q;
  assign pwr_hi_en = pwr_q;
  assign curbit    = curbit_q;
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_hf_reader_rx_engine.sv
// Directed bench for hf_reader_rx_engine (default parameters, default build).
module tb_hf_reader_rx_engine;

  logic       osc_clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] adc_d = 8'h80;
  logic [2:0] mod_type = 3'b000;
  logic [7:0] edge_threshold = 8'd5;
  logic       resync = 1'b0;
  logic       ssp_dout = 1'b0;
  logic       ssp_clk, ssp_frame, ssp_din, pwr_hi_en, curbit, rx_valid;
  logic [7:0] rx_byte;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;
  logic sq_en = 1'b0;

  logic       cb_log [256];
  logic       din_log [256];
  logic       pwr_log [256];
  logic       clk_log [256];
  logic       frm_log [256];
  logic       rxv_log [256];
  logic [7:0] rxb_log [256];

  hf_reader_rx_engine dut (
    .osc_clk        (osc_clk),
    .reset          (reset),
    .adc_d          (adc_d),
    .mod_type       (mod_type),
    .edge_threshold (edge_threshold),
    .resync         (resync),
    .ssp_dout       (ssp_dout),
    .ssp_clk        (ssp_clk),
    .ssp_frame      (ssp_frame),
    .ssp_din        (ssp_din),
    .pwr_hi_en      (pwr_hi_en),
    .curbit         (curbit),
    .rx_byte        (rx_byte),
    .rx_valid       (rx_valid)
  );

  always #5 osc_clk = ~osc_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One falling edge; sample t is square wave (8 low 0x60, 8 high 0xA0) or flat 0x80
  task automatic tick();
    adc_d = sq_en ? (((t % 16) >= 8) ? 8'hA0 : 8'h60) : 8'h80;
    @(negedge osc_clk);
    #1;
    t++;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    resync = 1'b0;
    adc_d  = 8'h80;
    repeat (3) begin
      @(negedge osc_clk);
      #1;
    end
    reset = 1'b0;
    t     = 0;
  endtask

  task automatic run_log(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (t - 1 < 256) begin
        cb_log[t-1]  = curbit;
        din_log[t-1] = ssp_din;
        pwr_log[t-1] = pwr_hi_en;
        clk_log[t-1] = ssp_clk;
        frm_log[t-1] = ssp_frame;
        rxv_log[t-1] = rx_valid;
        rxb_log[t-1] = rx_byte;
      end
    end
  endtask

  function automatic int count_ones(input int from, input int to, input int which);
    int c = 0;
    for (int i = from; i <= to; i++) begin
      case (which)
        0:       c += int'(cb_log[i]);
        1:       c += int'(din_log[i]);
        2:       c += int'(pwr_log[i]);
        default: c += int'(rxv_log[i]);
      endcase
    end
    return c;
  endfunction

  initial begin
    int rxv_cnt;
    logic frm7;

    // Flat input, idle mode
    sq_en = 1'b0; mod_type = 3'b000; edge_threshold = 8'd5;
    do_reset();
    check_eq("reset_outputs",
             {ssp_clk, ssp_frame, ssp_din, pwr_hi_en, curbit, rx_valid, rx_byte}, 32'h0);
    run_log(256);
    check_eq("ssp_clk_phases", {clk_log[0], clk_log[7], clk_log[8], clk_log[16]}, 32'b1101);
    check_eq("ssp_frame_edges", {frm_log[6], frm_log[7], frm_log[22], frm_log[23]}, 32'b0110);
    check_eq("ssp_frame_frame2", frm_log[135], 32'd1);
    check_eq("rx_valid_early", count_ones(0, 126, 3), 32'd0);
    check_eq("rx_valid_first", {rxv_log[127], rxv_log[128]}, 32'b10);
    check_eq("rx_byte_flat", rxb_log[127], 32'h00);
    check_eq("curbit_flat", count_ones(0, 255, 0), 32'd0);

    // Square wave, reader listen, low threshold
    sq_en = 1'b1; mod_type = 3'b011; edge_threshold = 8'd5;
    do_reset();
    run_log(256);
    check_eq("listen_curbit_win1", cb_log[4], 32'd0);
    check_eq("listen_curbit_win2", cb_log[20], 32'd1);
    check_eq("listen_din", {din_log[16], din_log[32]}, 32'b01);
    check_eq("listen_pwr", pwr_log[0], 32'd1);
    check_eq("listen_rx_first", {23'd0, rxv_log[127], rxb_log[127]}, 32'h13F);
    check_eq("listen_rx_second", {23'd0, rxv_log[255], rxb_log[255]}, 32'h1FF);

    // Same stimulus, idle mode
    mod_type = 3'b000;
    do_reset();
    run_log(256);
    check_eq("idle_curbit", cb_log[20], 32'd1);
    check_eq("idle_din", count_ones(0, 255, 1), 32'd0);
    check_eq("idle_pwr", count_ones(0, 255, 2), 32'd0);
    check_eq("idle_rx_byte", rxb_log[255], 32'hFF);

    // Threshold above peak edge magnitude (192)
    mod_type = 3'b011; edge_threshold = 8'd200;
    do_reset();
    run_log(256);
    check_eq("hithr_curbit", count_ones(0, 255, 0), 32'd0);
    check_eq("hithr_rx_byte", rxb_log[255], 32'h00);
    check_eq("hithr_din", din_log[32], 32'd0);

    // Strict comparison boundary around the 192 peak
    edge_threshold = 8'd192;
    do_reset();
    run_log(32);
    check_eq("thr192_curbit", cb_log[20], 32'd0);
    edge_threshold = 8'd191;
    do_reset();
    run_log(32);
    check_eq("thr191_curbit", cb_log[20], 32'd1);

    // Reader modulation: carrier follows ~ssp_dout one tick later
    sq_en = 1'b0; mod_type = 3'b100;
    do_reset();
    ssp_dout = 1'b1; tick(); check_eq("mod_pwr_a", pwr_hi_en, 32'd0);
    ssp_dout = 1'b0; tick(); check_eq("mod_pwr_b", pwr_hi_en, 32'd1);
    ssp_dout = 1'b1; tick(); check_eq("mod_pwr_c", pwr_hi_en, 32'd0);
    ssp_dout = 1'b0;

    // Resync at cnt 50 of the second frame
    sq_en = 1'b1; mod_type = 3'b011; edge_threshold = 8'd5;
    do_reset();
    repeat (178) tick();
    check_eq("pre_resync_clk", ssp_clk, 32'd1);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    check_eq("resync_clk_frame_valid", {ssp_clk, ssp_frame, rx_valid}, 32'b000);
    check_eq("resync_held", {22'd0, curbit, ssp_din, rx_byte}, 32'h33F);
    tick();
    check_eq("resync_cnt0_clk", ssp_clk, 32'd1);
    rxv_cnt = 0;
    frm7 = 1'b0;
    for (int i = 1; i < 127; i++) begin
      tick();
      if (rx_valid) rxv_cnt++;
      if (i == 7) frm7 = ssp_frame;
    end
    check_eq("resync_frame_cnt7", frm7, 32'd1);
    check_eq("resync_no_valid", rxv_cnt, 32'd0);
    tick();
    check_eq("resync_valid_128", rx_valid, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
